fxp_mul_pipe: RTL and testbench

Parametrised, pipelined signed fixed-point multiplier with valid/ready flow control, symmetric rounding and output saturation. It multiplies two two's-complement operands, rescales the product by a fixed binary point shift and rounds half away from zero. It then saturates to the output width and counts saturation events. It is the next-generation multiply primitive for the datapath: it adds backpressure, configurable latency and a narrowed, rounded output.

---
 rtl/fxp_mul_pipe.sv | 128 ++++++++++++
 tb/tb_fxp_mul_pipe.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/fxp_mul_pipe.sv
// Pipelined signed fixed-point multiplier: exact product, round half away from zero,
// saturation to OUT_W, global-stall valid/ready flow control and a saturation event counter.
module fxp_mul_pipe #(
    parameter int A_W        = 9,
    parameter int B_W        = 8,
    parameter int FRAC_SHIFT = 7,
    parameter int OUT_W      = 8,
    parameter int STAGES     = 2,
    parameter int CNT_W      = 16
) (
    input  logic                    clk,
    input  logic                    n_rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [A_W-1:0]   a,
    input  logic signed [B_W-1:0]   b,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [OUT_W-1:0] out_data,
    output logic                    out_sat,
    output logic [CNT_W-1:0]        sat_cnt,
    input  logic                    sat_clr
);

    localparam int P_W = A_W + B_W;
    localparam int HS  = (FRAC_SHIFT > 0) ? FRAC_SHIFT - 1 : 0;
    localparam logic [P_W:0] HALF = (FRAC_SHIFT > 0) ? ((P_W+1)'(1) << HS) : '0;
    localparam logic signed [P_W:0] MAX_R = {{(P_W-OUT_W+2){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [P_W:0] MIN_R = {{(P_W-OUT_W+2){1'b1}}, {(OUT_W-1){1'b0}}};
    localparam logic signed [OUT_W-1:0] MAX_O = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic signed [OUT_W-1:0] MIN_O = {1'b1, {(OUT_W-1){1'b0}}};

    // Rounds on the magnitude so that -P always maps to the negation of P's result.
    function automatic logic signed [P_W:0] round_hafz(input logic signed [P_W-1:0] p);
        logic [P_W:0] mag;
        logic [P_W:0] q;
        mag = {1'b0, (p[P_W-1] ? -p : p)};
        q   = (mag + HALF) >> FRAC_SHIFT;
        return p[P_W-1] ? -$signed(q) : $signed(q);
    endfunction

    // Returns {sat_flag, clipped value}.
    function automatic logic [OUT_W:0] saturate(input logic signed [P_W:0] r);
        if (r > MAX_R)
            return {1'b1, MAX_O};
        else if (r < MIN_R)
            return {1'b1, MIN_O};
        else
            return {1'b0, r[OUT_W-1:0]};
    endfunction

    logic                    w_adv;
    logic signed [P_W-1:0]   w_prod_p0;
    logic signed [P_W-1:0]   w_prod_last;
    logic                    w_vld_last;
    logic [OUT_W:0]          w_res;
    logic                    r_vld_out;
    logic signed [OUT_W-1:0] r_out_data;
    logic                    r_out_sat;
    logic [CNT_W-1:0]        r_sat_cnt;

    assign w_adv    = ~r_vld_out | out_ready;
    assign in_ready = w_adv;

    // Stage 0: operands sign-extended to full product width so the product is exact.
    assign w_prod_p0 = $signed({{B_W{a[A_W-1]}}, a}) * $signed({{A_W{b[B_W-1]}}, b});

    generate
        if (STAGES == 1) begin : g_direct
            assign w_prod_last = w_prod_p0;
            assign w_vld_last  = in_valid;
        end else begin : g_delay
            logic signed [P_W-1:0] r_prod_p [STAGES-1];
            logic                  r_vld_p  [STAGES-1];

            // Stages 1..STAGES-1: product and valid delay line under the global stall.
            always_ff @(posedge clk or negedge n_rst) begin
                if (!n_rst) begin
                    for (int i = 0; i < STAGES-1; i++) begin
                        r_prod_p[i] <= '0;
                        r_vld_p[i]  <= 1'b0;
                    end
                end else if (w_adv) begin
                    r_prod_p[0] <= w_prod_p0;
                    r_vld_p[0]  <= in_valid;
                    for (int i = 1; i < STAGES-1; i++) begin
                        r_prod_p[i] <= r_prod_p[i-1];
                        r_vld_p[i]  <= r_vld_p[i-1];
                    end
                end
            end

            assign w_prod_last = r_prod_p[STAGES-2];
            assign w_vld_last  = r_vld_p[STAGES-2];
        end
    endgenerate

    assign w_res = saturate(round_hafz(w_prod_last));

    // Final stage: rounded and saturated result drives the outputs directly.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_vld_out  <= 1'b0;
            r_out_data <= '0;
            r_out_sat  <= 1'b0;
        end else if (w_adv) begin
            r_vld_out  <= w_vld_last;
            r_out_sat  <= w_res[OUT_W];
            r_out_data <= w_res[OUT_W-1:0];
        end
    end

    // Clear wins over a simultaneous increment; the counter sticks at all-ones.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst)
            r_sat_cnt <= '0;
        else if (sat_clr)
            r_sat_cnt <= '0;
        else if (r_vld_out && out_ready && r_out_sat && (r_sat_cnt != '1))
            r_sat_cnt <= r_sat_cnt + CNT_W'(1);
    end

    assign out_valid = r_vld_out;
    assign out_data  = r_out_data;
    assign out_sat   = r_out_sat;
    assign sat_cnt   = r_sat_cnt;

endmodule

// File: tb/tb_fxp_mul_pipe.sv
// Directed bench for fxp_mul_pipe: default instance for arithmetic and backpressure,
// a STAGES=3 / CNT_W=2 instance for reset-mid-stream and counter edges.
module tb_fxp_mul_pipe;

    logic clk;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Default-parameter instance
    logic              n_rst, in_valid, in_ready, out_valid, out_ready, out_sat, sat_clr;
    logic signed [8:0] a;
    logic signed [7:0] b;
    logic signed [7:0] out_data;
    logic [15:0]       sat_cnt;

    fxp_mul_pipe u_dut (
        .clk(clk), .n_rst(n_rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_sat(out_sat), .sat_cnt(sat_cnt), .sat_clr(sat_clr)
    );

    // STAGES=3, CNT_W=2 instance
    logic              n_rst2, in_valid2, in_ready2, out_valid2, out_ready2, out_sat2, sat_clr2;
    logic signed [8:0] a2;
    logic signed [7:0] b2;
    logic signed [7:0] out_data2;
    logic [1:0]        sat_cnt2;

    fxp_mul_pipe #(.STAGES(3), .CNT_W(2)) u_dut2 (
        .clk(clk), .n_rst(n_rst2), .in_valid(in_valid2), .in_ready(in_ready2),
        .a(a2), .b(b2), .out_valid(out_valid2), .out_ready(out_ready2),
        .out_data(out_data2), .out_sat(out_sat2), .sat_cnt(sat_cnt2), .sat_clr(sat_clr2)
    );

    int n_total = 0;
    int n_bad   = 0;

    task automatic chk(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One pair on the default instance, checks latency, data, sat flag, then consumes it.
    task automatic run1(input string tag, input int av, input int bv, input int ed, input int es);
        int n;
        a        = 9'(av);
        b        = 8'(bv);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        n = 1;
        while (!out_valid && n < 10) begin
            tick();
            n++;
        end
        chk({tag, "_lat"}, n, 2);
        chk({tag, "_data"}, out_data, ed);
        chk({tag, "_sat"}, out_sat, es);
        tick();
    endtask

    int ta[6] = '{10, -20, 30, -45, 50, -61};
    int te[6] = '{5, -10, 15, -23, 25, -31};

    initial begin
        int sent, got, nv;
        logic acc, have_held;
        logic signed [7:0] held;

        n_rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1; sat_clr = 1'b0; a = '0; b = '0;
        n_rst2 = 1'b0; in_valid2 = 1'b0; out_ready2 = 1'b1; sat_clr2 = 1'b0; a2 = '0; b2 = '0;
        tick();
        tick();
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_sat", out_sat, 0);
        chk("rst_cnt", sat_cnt, 0);
        chk("rst_ready", in_ready, 1);
        n_rst  = 1'b1;
        n_rst2 = 1'b1;
        tick();

        // Exact products and symmetric rounding
        run1("p64x64", 64, 64, 32, 0);
        run1("p0xm128", 0, -128, 0, 0);
        run1("r3x64", 3, 64, 2, 0);
        run1("rm3x64", -3, 64, -2, 0);
        run1("r3x43", 3, 43, 1, 0);
        run1("rm3x43", -3, 43, -1, 0);

        // Saturation
        run1("s255x127", 255, 127, 127, 1);
        run1("sm256xm128", -256, -128, 127, 1);
        run1("sm256x127", -256, 127, -128, 1);
        chk("sat_cnt3", sat_cnt, 3);

        // Backpressure: six back-to-back pairs, out_ready low for three cycles
        sent = 0; got = 0; have_held = 1'b0; held = '0;
        for (int cyc = 0; cyc < 30; cyc++) begin
            out_ready = !(cyc >= 4 && cyc < 7);
            in_valid  = (sent < 6);
            if (sent < 6) begin
                a = 9'(ta[sent]);
                b = 8'sd64;
            end
            #1;
            if (out_valid && out_ready) begin
                if (got < 6) chk("bp_data", out_data, te[got]);
                else chk("bp_dup", got, 5);
                got++;
            end
            if (out_valid && !out_ready) begin
                chk("bp_in_ready", in_ready, 0);
                if (!have_held) begin
                    held      = out_data;
                    have_held = 1'b1;
                end else begin
                    chk("bp_hold", out_data, held);
                end
            end
            acc = in_valid && in_ready;
            tick();
            if (acc) sent++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        chk("bp_sent", sent, 6);
        chk("bp_got", got, 6);
        chk("bp_held_seen", have_held, 1);

        // Reset mid-stream on the STAGES=3 instance
        in_valid2 = 1'b1;
        a2 = 9'sd64;  b2 = 8'sd64; tick();
        a2 = 9'sd3;   b2 = 8'sd64; tick();
        a2 = -9'sd3;  b2 = 8'sd64; tick();
        in_valid2 = 1'b0;
        chk("mid_valid_pre", out_valid2, 1);
        chk("mid_data_pre", out_data2, 32);
        n_rst2 = 1'b0;
        #1;
        chk("mid_valid_rst", out_valid2, 0);
        chk("mid_data_rst", out_data2, 0);
        chk("mid_ready_rst", in_ready2, 1);
        tick();
        n_rst2 = 1'b1;
        tick();
        a2 = 9'sd10; b2 = 8'sd64; in_valid2 = 1'b1;
        tick();
        in_valid2 = 1'b0;
        nv = 0;
        for (int i = 0; i < 10; i++) begin
            if (out_valid2) begin
                nv++;
                chk("post_rst_data", out_data2, 5);
            end
            tick();
        end
        chk("post_rst_count", nv, 1);

        // Counter edges with CNT_W=2
        a2 = 9'sd255; b2 = 8'sd127; in_valid2 = 1'b1;
        repeat (4) tick();
        in_valid2 = 1'b0;
        repeat (8) tick();
        chk("cnt_sticky", sat_cnt2, 3);
        sat_clr2 = 1'b1;
        tick();
        sat_clr2 = 1'b0;
        chk("cnt_clr", sat_cnt2, 0);
        in_valid2 = 1'b1;
        tick();
        in_valid2 = 1'b0;
        nv = 0;
        while (!out_valid2 && nv < 10) begin
            tick();
            nv++;
        end
        chk("cnt_wait", out_valid2, 1);
        chk("cnt_sat_flag", out_sat2, 1);
        sat_clr2 = 1'b1;
        tick();
        sat_clr2 = 1'b0;
        chk("cnt_clr_prio", sat_cnt2, 0);
        chk("cnt_consumed", out_valid2, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
